lsu_data_mem: RTL
=================

// Module: lsu_data_mem
// PURPOSE
//  Parametrised load/store data memory for the RISC-V core with valid/ready request and response channels.
//  Supports byte, halfword and word access (LB/LH/LW/LBU/LHU, SB/SH/SW) selected by funct3.
//  Adds programmable wait states, plus error responses for misaligned, out-of-range or illegal accesses.
//  Sits between the datapath (ALU result as address, rs2 as store data) and the writeback mux.
// PARAMETERS
//  XLEN        32  data and address width in bits; must be 32.
//  DEPTH       64  memory depth in XLEN-bit words; must be a power of two, >= 4.
//  WAIT_CYC    1   wait states between request accept and memory commit; range 0..15.
// PORTS
//  clk         in   1     clock; all state changes on posedge.
//  reset       in   1     synchronous reset, active-low (0 = reset).
//  req_valid   in   1     request present.
//  req_ready   out  1     controller can accept a request.
//  req_write   in   1     1 = store, 0 = load.
//  req_funct3  in   3     access size/sign (RISC-V funct3 encoding).
//  req_addr    in   XLEN  byte address.
//  req_wdata   in   XLEN  store data; bytes taken from the LSBs.
//  rsp_valid   out  1     response present.
//  rsp_ready   in   1     consumer accepts the response.
//  rsp_rdata   out  XLEN  load result, extended per funct3; 0 for stores and errors.
//  rsp_err     out  1     1 = access rejected; memory is not modified.
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - Enter IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  - All DEPTH words cleared to 0; wait counter cleared.
//  - Reset mid-operation aborts the request; an uncommitted store is never written.
//  FSM IDLE -> WAIT -> RESP -> IDLE:
//  - IDLE: req_ready=1. On req_valid&req_ready, latch write/funct3/addr/wdata and evaluate the error.
//    - If error: go to RESP with rsp_err=1.
//    - Else if WAIT_CYC==0: commit and go to RESP.
//    - Else: load counter with WAIT_CYC-1 and go to WAIT.
//  - WAIT: req_ready=0. Decrement the counter; at 0, commit and go to RESP.
//  - RESP: rsp_valid=1; rsp_rdata and rsp_err hold stable. On rsp_ready, go to IDLE and drop rsp_valid.
//  - req_ready is 1 only in IDLE; no request is accepted in the cycle a response completes.
//  Latency and throughput:
//  - Accept at edge t gives rsp_valid high at edge t+1+WAIT_CYC.
//  - Error responses appear at t+1 regardless of WAIT_CYC.
//  - With rsp_ready tied high, one access per 2+WAIT_CYC cycles.
//  Addressing:
//  - Word index = addr[$clog2(DEPTH)+1:2]; byte lane = addr[1:0]; little-endian.
//  Errors (rsp_err=1, no state change other than the FSM):
//  - Out-of-range: addr >= 4*DEPTH.
//  - Misaligned: halfword with addr[0]!=0; word with addr[1:0]!=0.
//  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
//  Commit:
//  - Stores write only the addressed byte lanes at the commit edge; other lanes are unchanged.
//  - Loads sample the array at the commit edge.
//    - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
//  - A store response returns rsp_rdata=0, rsp_err=0.
//  - The request inputs are don't-care after acceptance.
// TESTING
//  1 Reset with reset=0 for 2 cycles -> all outputs at reset values; LW to 0x00 returns 0x00000000.
//  2 WAIT_CYC=1: SW 0x8000_00FF@0x04, then LB@0x04 -> 0xFFFFFFFF; LBU@0x04 -> 0x000000FF;
//    LH@0x06 -> 0xFFFF8000; rsp_valid exactly 2 cycles after each accept.
//  3 SB 0xAB@0x09 over a word holding 0x11223344 -> LW@0x08 returns 0x1122AB44.
//  4 LW@0x02, SH@0x03, LW@0x100 (DEPTH=64), funct3=011 load -> each gives rsp_err=1 one cycle after
//    accept, rsp_rdata=0, and memory is unchanged.
//  5 rsp_ready held low 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0;
//    a new request presented meanwhile is not accepted until the cycle after the rsp handshake.
//  6 Reset asserted during WAIT of SW 0xDEADBEEF@0x10 (WAIT_CYC=3) -> after release,
//    LW@0x10 returns 0 and no stray rsp_valid appears.

Source files
------------

// File: rtl/lsu_data_mem_if.sv
// Request/response channel bundle between the datapath and the load/store data memory.
interface lsu_data_mem_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_data_mem.sv
// Load/store data memory with byte/half/word access, programmable wait states and
// error responses for misaligned, out-of-range or illegal-funct3 accesses.
module lsu_data_mem #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 64,
    parameter int WAIT_CYC = 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    lsu_data_mem_if.slave bus
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic access_error(input logic            wr,
                                          input logic [2:0]      f3,
                                          input logic [XLEN-1:0] addr);
        logic out_of_range_s;
        logic misaligned_s;
        logic illegal_s;
        out_of_range_s = |addr[XLEN-1:AW+2];
        case (f3)
            3'b000: begin misaligned_s = 1'b0;       illegal_s = 1'b0; end
            3'b001: begin misaligned_s = addr[0];    illegal_s = 1'b0; end
            3'b010: begin misaligned_s = |addr[1:0]; illegal_s = 1'b0; end
            3'b100: begin misaligned_s = 1'b0;       illegal_s = wr;   end
            3'b101: begin misaligned_s = addr[0];    illegal_s = wr;   end
            default: begin misaligned_s = 1'b0;      illegal_s = 1'b1; end
        endcase
        return out_of_range_s | misaligned_s | illegal_s;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [2:0]      f3,
                                                     input logic [1:0]      lane);
        logic [7:0]      byte_s;
        logic [15:0]     half_s;
        logic [XLEN-1:0] res_s;
        byte_s = word[{lane, 3'b000} +: 8];
        half_s = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res_s = {{(XLEN-8){byte_s[7]}}, byte_s};
            3'b001:  res_s = {{(XLEN-16){half_s[15]}}, half_s};
            3'b010:  res_s = word;
            3'b100:  res_s = {{(XLEN-8){1'b0}}, byte_s};
            3'b101:  res_s = {{(XLEN-16){1'b0}}, half_s};
            default: res_s = {XLEN{1'b0}};
        endcase
        return res_s;
    endfunction

    function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old,
                                                    input logic [XLEN-1:0] wdata,
                                                    input logic [2:0]      f3,
                                                    input logic [1:0]      lane);
        logic [XLEN-1:0] mask_s;
        logic [XLEN-1:0] data_s;
        case (f3)
            3'b000: begin
                mask_s = {{(XLEN-8){1'b0}}, 8'hFF} << {lane, 3'b000};
                data_s = {{(XLEN-8){1'b0}}, wdata[7:0]} << {lane, 3'b000};
            end
            3'b001: begin
                mask_s = {{(XLEN-16){1'b0}}, 16'hFFFF} << {lane[1], 4'b0000};
                data_s = {{(XLEN-16){1'b0}}, wdata[15:0]} << {lane[1], 4'b0000};
            end
            3'b010: begin
                mask_s = {XLEN{1'b1}};
                data_s = wdata;
            end
            default: begin
                mask_s = {XLEN{1'b0}};
                data_s = {XLEN{1'b0}};
            end
        endcase
        return (old & ~mask_s) | (data_s & mask_s);
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [2:0]      f3_q, f3_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] mem_q [DEPTH];

    logic            commit_s;
    logic            c_wr_s;
    logic [2:0]      c_f3_s;
    logic [AW+1:0]   c_addr_s;
    logic [XLEN-1:0] c_wdata_s;
    logic [XLEN-1:0] c_word_s;
    logic [XLEN-1:0] merged_s;
    logic [XLEN-1:0] load_s;

    // Commit operands: live request when committing straight from IDLE, latched copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            c_wr_s    = bus.req_write;
            c_f3_s    = bus.req_funct3;
            c_addr_s  = bus.req_addr[AW+1:0];
            c_wdata_s = bus.req_wdata;
        end else begin
            c_wr_s    = wr_q;
            c_f3_s    = f3_q;
            c_addr_s  = addr_q;
            c_wdata_s = wdata_q;
        end
        c_word_s = mem_q[c_addr_s[AW+1:2]];
        merged_s = store_merge(c_word_s, c_wdata_s, c_f3_s, c_addr_s[1:0]);
        load_s   = c_wr_s ? {XLEN{1'b0}} : load_extract(c_word_s, c_f3_s, c_addr_s[1:0]);
    end

    // Next-state and response data for the IDLE -> WAIT -> RESP sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr[AW+1:0];
                    wdata_d = bus.req_wdata;
                    if (access_error(bus.req_write, bus.req_funct3, bus.req_addr)) begin
                        state_d = ST_RESP;
                        rdata_d = {XLEN{1'b0}};
                        err_d   = 1'b1;
                    end else if (WAIT_CYC == 0) begin
                        commit_s = 1'b1;
                        state_d  = ST_RESP;
                        rdata_d  = load_s;
                        err_d    = 1'b0;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit_s = 1'b1;
                    state_d  = ST_RESP;
                    rdata_d  = load_s;
                    err_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State, latched request, response registers and the memory array.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= {(AW+2){1'b0}};
            wdata_q     <= {XLEN{1'b0}};
            rdata_q     <= {XLEN{1'b0}};
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            if (commit_s && c_wr_s) begin
                mem_q[c_addr_s[AW+1:2]] <= merged_s;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
